// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ byte sources.
// Define TX_OWNER_PREFIX_EN to send an owner-tag frame (8'hA0 | owner) before every data byte.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [2:0]         owner,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic               err
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]       owner_q, owner_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             err_q, err_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef TX_OWNER_PREFIX_EN
  logic [7:0]       byte_q, byte_d;
  logic             second_q, second_d;
`endif

  // Requests and bytes widened to 8 lanes so a 3-bit index is always legal.
  logic [7:0] lane_req;
  logic [7:0] lane_byte [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    if (gi < N_REQ) begin : g_on
      assign lane_req[gi]  = req[gi];
      assign lane_byte[gi] = data_in[8*gi +: 8];
    end else begin : g_off
      assign lane_req[gi]  = 1'b0;
      assign lane_byte[gi] = 8'h00;
    end
  end

  logic       found;
  logic [2:0] sel;
  logic [3:0] rr_idx;

  always_comb begin
    found  = 1'b0;
    sel    = 3'd0;
    rr_idx = 4'd0;
    for (int k = 0; k < N_REQ; k++) begin
      rr_idx = {1'b0, ptr_q} + 4'(k);
      if (rr_idx >= 4'(N_REQ)) rr_idx = rr_idx - 4'(N_REQ);
      if (!found && lane_req[rr_idx[2:0]]) begin
        found = 1'b1;
        sel   = rr_idx[2:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = '0;
    owner_d    = owner_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_d      = 1'b0;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
`ifdef TX_OWNER_PREFIX_EN
    byte_d     = byte_q;
    second_d   = second_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!tx_busy && found) begin
          for (int i = 0; i < N_REQ; i++) gnt_d[i] = (3'(i) == sel);
          owner_d = sel;
          ptr_d   = (sel == 3'(N_REQ - 1)) ? 3'd0 : sel + 3'd1;
`ifdef TX_OWNER_PREFIX_EN
          tx_data_d = {5'b10100, sel};
          byte_d    = lane_byte[sel];
          second_d  = 1'b1;
`else
          tx_data_d = lane_byte[sel];
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        tx_start_d = 1'b1;
        cnt_d      = '0;
        state_d    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Transmitter never acknowledged; abandon the whole grant.
          err_d   = 1'b1;
          state_d = S_IDLE;
`ifdef TX_OWNER_PREFIX_EN
          second_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
`ifdef TX_OWNER_PREFIX_EN
          if (second_q) begin
            tx_data_d = byte_q;
            second_d  = 1'b0;
            state_d   = S_START;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      owner_q    <= 3'd0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
      ptr_q      <= 3'd0;
      cnt_q      <= '0;
`ifdef TX_OWNER_PREFIX_EN
      byte_q     <= 8'h00;
      second_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      err_q      <= err_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
`ifdef TX_OWNER_PREFIX_EN
      byte_q     <= byte_d;
      second_q   <= second_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign owner    = owner_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table plus directed multi-cycle sequences with a reactive busy model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  gnt;
  logic [2:0]  owner;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        err;

`ifdef TX_OWNER_PREFIX_EN
  localparam int FRAMES = 2;
  localparam int N_VEC  = 4;
`else
  localparam int FRAMES = 1;
  localparam int N_VEC  = 19;
`endif

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .gnt(gnt), .owner(owner),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic       busy;
    logic [3:0] e_gnt;
    logic [2:0] e_owner;
    logic [7:0] e_txd;
    logic       e_start;
    logic       e_err;
  } vec_t;

  vec_t vecs [N_VEC];

  function automatic vec_t v(input logic r, input logic [3:0] q, input logic b, input logic [3:0] g,
                             input logic [2:0] o, input logic [7:0] d, input logic s, input logic e);
    vec_t x;
    x = '{rst: r, req: q, busy: b, e_gnt: g, e_owner: o, e_txd: d, e_start: s, e_err: e};
    return x;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Busy model and scoreboard state
  logic       model_en;
  int         busy_len;
  int         rem;
  bit         start_pend;
  bit         prev_gnt;
  int         since_fall;
  bit         fall_seen;
  bit         gap_chk;
  logic [7:0] exp_q [$];
  int         n_gnt, n_start, n_err, last_idx, cyc;

  task automatic clear_model();
    n_gnt = 0; n_start = 0; n_err = 0; fall_seen = 0; prev_gnt = 0;
  endtask

  task automatic step_model();
    int idx;
    @(posedge clk); #1;
    cyc++;
    since_fall++;
    if (|gnt || tx_start || err)
      chk("exclusive", 32'(int'(|gnt) + int'(tx_start) + int'(err)), 1);
    if (prev_gnt) chk("start_after_gnt", tx_start, 1);
    if (tx_start) begin
      n_start++;
      chk("frame_queued", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("tx_data", tx_data, exp_q.pop_front());
    end
    if (|gnt) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (gnt[i]) idx = i;
      chk("gnt_onehot", $countones(gnt), 1);
      chk("owner", owner, idx);
      if (gap_chk && fall_seen) chk("gap_after_busy", since_fall, 2);
`ifdef TX_OWNER_PREFIX_EN
      exp_q.push_back(8'hA0 | 8'(idx));
`endif
      exp_q.push_back(data_in[8*idx +: 8]);
      n_gnt++;
      last_idx = idx;
      $display("grant: requester %0d byte 0x%0h at cycle %0d", idx, data_in[8*idx +: 8], cyc);
    end
    if (err) begin
      n_err++;
      exp_q.delete();
    end
    prev_gnt = |gnt;
    if (start_pend) begin
      tx_busy = 1'b1; rem = busy_len; start_pend = 0;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) begin tx_busy = 1'b0; since_fall = 0; fall_seen = 1; end
    end
    if (tx_start && model_en) start_pend = 1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = 4'hF; tx_busy = 1'b0;
    rem = 0; start_pend = 0; exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {gnt, owner, tx_data, tx_start, err}, 0);
    rst = 1'b1; req = 4'h0;
    clear_model();
  endtask

  int fair_order [5] = '{0, 1, 2, 3, 0};
  int t_start, t_err, t_gnt2, busy_hi, c;

  initial begin
    rst = 1'b0; req = 4'h0; tx_busy = 1'b0; cyc = 0; since_fall = 0;
    data_in = {8'h44, 8'h2A, 8'h22, 8'h11};
    model_en = 1'b0; busy_len = 5; rem = 0; start_pend = 0; gap_chk = 0; last_idx = 0;
    clear_model();

    // rst, req, busy -> gnt, owner, tx_data, tx_start, err after the edge
    vecs[0]  = v(0, 4'hF, 0, 4'h0, 0, 8'h00, 0, 0);
    vecs[1]  = v(0, 4'hF, 0, 4'h0, 0, 8'h00, 0, 0);
`ifdef TX_OWNER_PREFIX_EN
    vecs[2]  = v(1, 4'hF, 0, 4'h1, 0, 8'hA0, 0, 0);
    vecs[3]  = v(1, 4'h0, 0, 4'h0, 0, 8'hA0, 1, 0);
`else
    vecs[2]  = v(1, 4'hF, 0, 4'h1, 0, 8'h11, 0, 0);
    vecs[3]  = v(1, 4'h0, 0, 4'h0, 0, 8'h11, 1, 0);
    vecs[4]  = v(1, 4'h0, 0, 4'h0, 0, 8'h11, 0, 0);
    vecs[5]  = v(1, 4'h0, 1, 4'h0, 0, 8'h11, 0, 0);
    vecs[6]  = v(1, 4'h4, 1, 4'h0, 0, 8'h11, 0, 0);
    vecs[7]  = v(1, 4'h4, 0, 4'h0, 0, 8'h11, 0, 0);
    vecs[8]  = v(1, 4'h4, 0, 4'h4, 2, 8'h2A, 0, 0);
    vecs[9]  = v(1, 4'h0, 0, 4'h0, 2, 8'h2A, 1, 0);
    vecs[10] = v(1, 4'h0, 1, 4'h0, 2, 8'h2A, 0, 0);
    vecs[11] = v(1, 4'h0, 0, 4'h0, 2, 8'h2A, 0, 0);
    vecs[12] = v(1, 4'h8, 1, 4'h0, 2, 8'h2A, 0, 0);
    vecs[13] = v(1, 4'h8, 0, 4'h8, 3, 8'h44, 0, 0);
    vecs[14] = v(1, 4'h0, 0, 4'h0, 3, 8'h44, 1, 0);
    vecs[15] = v(1, 4'h0, 1, 4'h0, 3, 8'h44, 0, 0);
    vecs[16] = v(1, 4'h0, 0, 4'h0, 3, 8'h44, 0, 0);
    vecs[17] = v(1, 4'h3, 0, 4'h1, 0, 8'h11, 0, 0);
    vecs[18] = v(1, 4'h0, 0, 4'h0, 0, 8'h11, 1, 0);
`endif

    for (int i = 0; i < N_VEC; i++) begin
      rst = vecs[i].rst; req = vecs[i].req; tx_busy = vecs[i].busy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), {gnt, owner, tx_data, tx_start, err},
          {vecs[i].e_gnt, vecs[i].e_owner, vecs[i].e_txd, vecs[i].e_start, vecs[i].e_err});
      $display("vector %0d: gnt=%b owner=%0d tx_data=0x%0h tx_start=%b err=%b",
               i, gnt, owner, tx_data, tx_start, err);
    end

    // Fairness: all requesters held high
    do_reset();
    model_en = 1'b1; busy_len = 5; gap_chk = 1; req = 4'hF;
    for (c = 0; c < 400; c++) begin
      step_model();
      if (|gnt) begin
        if (n_gnt <= 5) chk("rr_order", last_idx, fair_order[n_gnt-1]);
        if (n_gnt == 5) req = 4'h0;
      end
      if (n_gnt == 5 && exp_q.size() == 0 && rem == 0 && !start_pend) break;
    end
    chk("fair_finished", c < 400, 1);
    chk("fair_starts", n_start, 5 * FRAMES);
    chk("fair_no_err", n_err, 0);

    // Single requester with a full-length frame, then re-request after busy falls
    clear_model();
    busy_len = 2778; gap_chk = 1; req = 4'b0100;
    for (c = 0; c < 7000 && n_gnt < 2; c++) begin
      step_model();
      if (|gnt) req = 4'h0;
      if (n_gnt == 1 && fall_seen && exp_q.size() == 0 && rem == 0 && !start_pend && req == 4'h0)
        req = 4'b0100;
    end
    chk("single_regrant", n_gnt, 2);
    chk("single_starts", n_start, FRAMES);
    chk("single_owner", owner, 2);

    // Start-acknowledge timeout with busy stuck low
    do_reset();
    model_en = 1'b0; gap_chk = 0; req = 4'b0010;
    t_start = -1; t_err = -1; t_gnt2 = -1;
    for (c = 0; c < 100 && n_gnt < 2; c++) begin
      step_model();
      if (tx_start && t_start < 0) t_start = cyc;
      if (err) t_err = cyc;
      if (|gnt && n_gnt == 2) t_gnt2 = cyc;
    end
    chk("timeout_delay", t_err - t_start, 16);
    chk("regrant_after_err", t_gnt2 - t_err, 1);
    chk("regrant_idx", last_idx, 1);
    chk("err_count", n_err, 1);

    // Reset during WAIT_DONE
    do_reset();
    model_en = 1'b1; busy_len = 50; gap_chk = 0; req = 4'b0100;
    busy_hi = 0;
    for (c = 0; c < 200 && busy_hi < 5; c++) begin
      step_model();
      if (|gnt) req = 4'h0;
      if (tx_busy) busy_hi++;
    end
    chk("midrst_reached", busy_hi, 5);
    rst = 1'b0; tx_busy = 1'b0; rem = 0; start_pend = 0; exp_q.delete(); req = 4'b1001;
    @(posedge clk); #1;
    chk("midrst_outputs", {gnt, owner, tx_data, tx_start, err}, 0);
    rst = 1'b1;
    clear_model();
    for (c = 0; c < 10 && n_gnt == 0; c++) step_model();
    chk("midrst_ptr", gnt, 4'b0001);

    // One grant of requester 3 (two frames when the owner prefix is enabled)
    do_reset();
    model_en = 1'b1; busy_len = 5; gap_chk = 0;
    data_in[31:24] = 8'h55; req = 4'b1000;
    for (c = 0; c < 200; c++) begin
      step_model();
      if (|gnt) req = 4'h0;
      if (n_gnt == 1 && exp_q.size() == 0 && rem == 0 && !start_pend) break;
    end
    chk("pair_finished", c < 200, 1);
    chk("pair_starts", n_start, FRAMES);
    chk("pair_grants", n_gnt, 1);
    chk("pair_owner", owner, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (32 MHz clock, 115200 baud) between N_REQ byte requesters.
- Grants requesters round-robin, latches the granted byte and pulses the transmitter start.
- Tracks the transmitter busy handshake through to completion, with a start-acknowledge timeout.
- Sits between the protocol/debug sources and the UART transmitter, mirroring the Receiver on the RX side.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 16, clock cycles allowed for tx_busy to rise after tx_start (>=2)

Ports:
clk  input  1  system clock, 32 MHz
rst  input  1  synchronous reset, active-low (asserted when 0)
req  input  N_REQ  per-requester request, level
data_in  input  8*N_REQ  byte of requester i on data_in[8*i+7:8*i]
gnt  output  N_REQ  one-cycle one-hot pulse: byte of requester i accepted
owner  output  3  index of last granted requester
tx_data  output  8  byte to transmitter
tx_start  output  1  one-cycle start pulse to transmitter
tx_busy  input  1  transmitter busy (frame in progress)
err  output  1  one-cycle pulse: TIMEOUT expired without tx_busy rising

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE, gnt=0, owner=0, tx_data=8'h00, tx_start=0, err=0, RR pointer=0, timeout counter=0. Reset wins over every other event, including mid-frame.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE. Only WAIT_BUSY runs the counter.
- IDLE: if tx_busy=0 and req!=0, grant the first set req[i], searching from pointer upward with wrap (pointer, pointer+1, ... N_REQ-1, 0, ...).
  - Same edge: latch tx_data=data_in[i], owner=i, gnt[i]=1 for one cycle, pointer=(i+1) mod N_REQ, go to START.
  - If tx_busy=1 in IDLE, no grant.
- START: tx_start=1 for exactly this one cycle, tx_data stable; counter=0; go to WAIT_BUSY.
- WAIT_BUSY:
  - if tx_busy=1 -> WAIT_DONE.
  - else if counter=TIMEOUT-1 -> err=1 for one cycle, go to IDLE.
  - else counter+1.
- WAIT_DONE: when tx_busy=0 -> IDLE. No new grant in the same cycle; earliest next gnt is the cycle after returning to IDLE.
- Grant-to-tx_start latency is 1 cycle. Back-to-back bytes have a minimum gap of 1 IDLE cycle after busy falls.
- Requester contract:
  - deassert req on the cycle after its gnt pulse.
  - req still high then is a new request, served in round-robin order.
  - data_in is sampled only on the grant edge.
- tx_data holds the latched byte until the next grant or reset.
- gnt, tx_start and err are never asserted together.
- Invalid state encoding recovers to IDLE.

Optional Feature:
- Macro TX_OWNER_PREFIX_EN.
- Defined: each grant sends two frames. First tx_data=8'hA0|owner (prefix), then the data byte.
  - After the prefix completes WAIT_DONE, go directly to START with the data byte; no re-arbitration.
  - A timeout on either frame pulses err, aborts the pair and returns to IDLE.
  - gnt still pulses once, at grant.
- Undefined: single frame per grant as above; prefix logic absent.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req=4'b1111 -> gnt=0, tx_start=0, tx_data=8'h00, err=0; release -> first gnt=4'b0001, then tx_start and tx_data=data_in[0].
- Single requester: req[2]=1, data_in[2]=8'd42, model busy rises 1 cycle after tx_start and lasts 2778 cycles -> gnt=4'b0100, tx_start one cycle later with tx_data=8'd42, owner=2, IDLE after busy falls.
- Fairness: req=4'b1111 held continuously -> grant order 0,1,2,3,0; exactly one tx_start per busy period.
- Timeout: tx_busy tied 0 with req[1]=1 -> tx_start, then err pulse exactly TIMEOUT=16 cycles later; re-grant of requester 1 follows.
- Reset mid-frame: rst=0 during WAIT_DONE -> next edge state IDLE, pointer=0; after release with busy=0 and req=4'b1000 -> gnt=4'b1000.
- TX_OWNER_PREFIX_EN: req[3]=1, data 8'h55 -> tx_data sequence 8'hA3 then 8'h55, two tx_start pulses, one gnt pulse.
